piso_serializer: RTL and testbench

//   Parallel-in/serial-out transmitter. Accepts a WIDTH-bit word over a valid/ready handshake
//   and shifts it out one bit per clock on ser_out, with ser_valid and frame_start qualifiers.

---
 rtl/piso_pkg.sv | 15 +
 rtl/piso_serializer_bit_counter.sv | 35 +++
 rtl/piso_serializer.sv | 145 ++++++++++++++
 tb/tb_piso_serializer.sv | 246 ++++++++++++++++++++++++
 4 files changed

// File: rtl/piso_pkg.sv
// piso_pkg: shared definitions for the PISO serializer.
//   STATE_W  width of the FSM state encoding
//   state_t  FSM states: ST_IDLE, ST_SHIFT, ST_PARITY
// ST_PARITY is only reachable when the design is built with PARITY_EN.
package piso_pkg;

   localparam int STATE_W = 2;

   typedef enum logic [STATE_W-1:0] {
      ST_IDLE   = 2'd0,
      ST_SHIFT  = 2'd1,
      ST_PARITY = 2'd2
   } state_t;

endpackage

// File: rtl/piso_serializer_bit_counter.sv
// bit_counter: loadable down-counter with a terminal-count flag.
// Shared between the serial transmitter and the serial receiver.
// Ports:
//   clk       in   clock, rising edge
//   rst       in   synchronous active-high reset, clears the count
//   load      in   load load_val (has priority over en)
//   load_val  in   value loaded on load
//   en        in   decrement by one; saturates at zero and never wraps
//   tc        out  terminal count, high while the count is zero
module bit_counter #(
   parameter int CW = 4
) (
   input  logic          clk,
   input  logic          rst,
   input  logic          load,
   input  logic [CW-1:0] load_val,
   input  logic          en,
   output logic          tc
);

   logic [CW-1:0] count;

   always_ff @(posedge clk) begin
      if (rst) begin
         count <= '0;
      end else if (load) begin
         count <= load_val;
      end else if (en && (count != '0)) begin
         count <= count - CW'(1);
      end
   end

   assign tc = (count == '0);

endmodule

// File: rtl/piso_serializer.sv
// piso_serializer: parallel-in / serial-out transmitter.
// A WIDTH-bit word is taken over a valid/ready handshake and shifted out one
// bit per clock on ser_out, starting the cycle after the accept.
// Optional build macro: PARITY_EN adds one even-parity bit after the data bits.
//
// Handshake: a word is accepted on a rising edge where par_valid && par_ready;
// par_data is sampled only at that edge. par_valid may be held or dropped freely
// while par_ready is low; nothing is captured. par_ready is low during rst.
//
// Ports:
//   clk          in   clock, rising edge
//   rst          in   synchronous active-high reset; aborts any frame in flight
//   par_data     in   WIDTH-bit word, sampled on accept
//   par_valid    in   upstream offers a word
//   par_ready    out  word can be accepted this cycle (combinational)
//   ser_out      out  serial data bit (0 when idle)
//   ser_valid    out  ser_out carries a frame bit
//   frame_start  out  first bit of a frame
//   busy         out  frame in progress (same as ser_valid)
module piso_serializer
   import piso_pkg::*;
#(
   parameter int WIDTH     = 8,
   parameter bit MSB_FIRST = 1'b1
) (
   input  logic             clk,
   input  logic             rst,
   input  logic [WIDTH-1:0] par_data,
   input  logic             par_valid,
   output logic             par_ready,
   output logic             ser_out,
   output logic             ser_valid,
   output logic             frame_start,
   output logic             busy
);

   localparam int CNT_W = $clog2(WIDTH + 1);

   state_t           state;
   logic [WIDTH-1:0] shreg;       // bits still to be sent after the one on ser_out
   logic             accept;
   logic             cnt_tc;      // current bit is the last data bit
   logic             cnt_en;
   logic             last_bit;
   logic             first_bit;
   logic             next_bit;
   logic [WIDTH-1:0] load_rest;
   logic [WIDTH-1:0] shift_rest;
`ifdef PARITY_EN
   logic             parity_bit;
`endif

   // Bit order selection: the bit leaving next always sits at the end of the
   // register that faces ser_out, so shifting is one direction per order.
   always_comb begin
      if (MSB_FIRST) begin
         first_bit  = par_data[WIDTH-1];
         load_rest  = par_data << 1;
         next_bit   = shreg[WIDTH-1];
         shift_rest = shreg << 1;
      end else begin
         first_bit  = par_data[0];
         load_rest  = par_data >> 1;
         next_bit   = shreg[0];
         shift_rest = shreg >> 1;
      end
   end

   assign last_bit = (state == ST_SHIFT) && cnt_tc;
   assign cnt_en   = (state == ST_SHIFT) && !cnt_tc;

   // Ready in the final cycle of a frame so the next frame follows with no gap.
`ifdef PARITY_EN
   assign par_ready = !rst && ((state == ST_IDLE) || (state == ST_PARITY));
`else
   assign par_ready = !rst && ((state == ST_IDLE) || last_bit);
`endif

   assign accept = par_valid && par_ready;
   assign busy   = ser_valid;

   // Counter holds the number of data bits remaining after the current one.
   bit_counter #(
      .CW (CNT_W)
   ) u_bit_counter (
      .clk      (clk),
      .rst      (rst),
      .load     (accept),
      .load_val (CNT_W'(WIDTH - 1)),
      .en       (cnt_en),
      .tc       (cnt_tc)
   );

   always_ff @(posedge clk) begin
      if (rst) begin
         state       <= ST_IDLE;
         shreg       <= '0;
         ser_out     <= 1'b0;
         ser_valid   <= 1'b0;
         frame_start <= 1'b0;
`ifdef PARITY_EN
         parity_bit  <= 1'b0;
`endif
      end else begin
         frame_start <= 1'b0;
         // accept can only occur in IDLE, the last data bit or PARITY, so it
         // takes priority over every other transition.
         if (accept) begin
            state       <= ST_SHIFT;
            shreg       <= load_rest;
            ser_out     <= first_bit;
            ser_valid   <= 1'b1;
            frame_start <= 1'b1;
`ifdef PARITY_EN
            parity_bit  <= ^par_data;
`endif
         end else begin
            case (state)
               ST_SHIFT: begin
                  if (!cnt_tc) begin
                     ser_out <= next_bit;
                     shreg   <= shift_rest;
                  end else begin
`ifdef PARITY_EN
                     state   <= ST_PARITY;
                     ser_out <= parity_bit;
`else
                     state     <= ST_IDLE;
                     ser_out   <= 1'b0;
                     ser_valid <= 1'b0;
`endif
                  end
               end
               default: begin
                  // ST_IDLE, and ST_PARITY without a follow-on word
                  state     <= ST_IDLE;
                  ser_out   <= 1'b0;
                  ser_valid <= 1'b0;
               end
            endcase
         end
      end
   end

endmodule

// File: tb/tb_piso_serializer.sv
// tb_piso_serializer: bench for piso_serializer (WIDTH=8).
// Two instances share the stimulus: one MSB-first, one LSB-first.
// Build with +define+PARITY_EN to exercise the parity build.
module tb_piso_serializer;

   localparam int W = 8;
`ifdef PARITY_EN
   localparam int FL = W + 1;
`else
   localparam int FL = W;
`endif

   // ---------------- clock / reset ----------------
   logic         clk       = 1'b0;
   logic         rst       = 1'b1;
   logic         par_valid = 1'b0;
   logic [W-1:0] par_data  = '0;

   logic ready_m, out_m, valid_m, fs_m, busy_m;
   logic ready_l, out_l, valid_l, fs_l, busy_l;

   always #5 clk = ~clk;

   piso_serializer #(.WIDTH(W), .MSB_FIRST(1'b1)) u_msb (
      .clk(clk), .rst(rst), .par_data(par_data), .par_valid(par_valid),
      .par_ready(ready_m), .ser_out(out_m), .ser_valid(valid_m),
      .frame_start(fs_m), .busy(busy_m)
   );

   piso_serializer #(.WIDTH(W), .MSB_FIRST(1'b0)) u_lsb (
      .clk(clk), .rst(rst), .par_data(par_data), .par_valid(par_valid),
      .par_ready(ready_l), .ser_out(out_l), .ser_valid(valid_l),
      .frame_start(fs_l), .busy(busy_l)
   );

   // ---------------- scoreboard ----------------
   // One queue entry per future output cycle; cur is what the outputs show now.
   typedef struct packed {
      logic v;
      logic bm;
      logic bl;
      logic fs;
   } ent_t;

   ent_t exp_q[$];
   ent_t cur      = '0;
   int   n_checks = 0;
   int   n_err    = 0;
   bit   chk_en   = 1'b0;

   task automatic chk(input string name, input logic act, input logic exp);
      n_checks++;
      if (act !== exp) begin
         n_err++;
         $display("FAIL %s at %0t: got %b expected %b", name, $time, act, exp);
      end
   endtask

   // Ready exactly when nothing beyond the current output remains queued.
   function automatic bit m_ready();
      return !rst && (exp_q.size() == 0);
   endfunction

   always @(posedge clk) begin
      if (rst) begin
         exp_q.delete();
         cur = '0;
      end else begin
         if (par_valid && (exp_q.size() == 0)) begin
            for (int i = 0; i < W; i++) begin
               ent_t e;
               e.v  = 1'b1;
               e.bm = par_data[W-1-i];
               e.bl = par_data[i];
               e.fs = (i == 0);
               exp_q.push_back(e);
            end
`ifdef PARITY_EN
            begin
               ent_t p;
               p.v  = 1'b1;
               p.bm = ^par_data;
               p.bl = ^par_data;
               p.fs = 1'b0;
               exp_q.push_back(p);
            end
`endif
         end
         if (exp_q.size() > 0) cur = exp_q.pop_front();
         else                  cur = '0;
      end
   end

   // Compare process: every cycle once reset has been applied.
   always @(negedge clk) begin
      if (chk_en) begin
         chk("m_ser_valid",   valid_m, cur.v);
         chk("m_ser_out",     out_m,   cur.bm);
         chk("m_frame_start", fs_m,    cur.fs);
         chk("m_busy",        busy_m,  cur.v);
         chk("m_par_ready",   ready_m, m_ready());
         chk("l_ser_valid",   valid_l, cur.v);
         chk("l_ser_out",     out_l,   cur.bl);
         chk("l_frame_start", fs_l,    cur.fs);
         chk("l_par_ready",   ready_l, m_ready());
      end
   end

   // ---------------- driver tasks ----------------
   // Offers d until accepted; returns 1 time unit after the accepting edge.
   task automatic send(input logic [W-1:0] d, input bit hold);
      bit got;
      par_data  = d;
      par_valid = 1'b1;
      for (int i = 0; i < 100; i++) begin
         @(negedge clk);
         got = m_ready();
         @(posedge clk);
         #1;
         if (got) begin
            if (!hold) par_valid = 1'b0;
            return;
         end
      end
      chk("send_timeout", 1'b1, 1'b0);
      par_valid = 1'b0;
   endtask

   // Hand-derived frame check starting at the next negedge.
   task automatic check_frame(input logic [W-1:0] d, input bit lsb, input string tag);
      logic [W-1:0] w;
      logic         e;
      w = d;
      for (int i = 0; i < FL; i++) begin
         @(negedge clk);
         if (i < W) e = lsb ? w[i] : w[W-1-i];
         else       e = ^w;
         chk({tag, "_bit"}, lsb ? out_l : out_m, e);
         chk({tag, "_fs"},  lsb ? fs_l  : fs_m,  (i == 0));
      end
   endtask

   initial begin
      #200000;
      $display("FAIL global_timeout: got no finish expected finish");
      $fatal(1);
   end

   // ---------------- main sequence ----------------
   initial begin
      rst = 1'b1;
      repeat (3) @(posedge clk);
      @(negedge clk);
      chk("rst_ser_valid",   valid_m, 1'b0);
      chk("rst_ser_out",     out_m,   1'b0);
      chk("rst_frame_start", fs_m,    1'b0);
      chk("rst_busy",        busy_m,  1'b0);
      chk("rst_par_ready",   ready_m, 1'b0);
      @(posedge clk); #1;
      rst    = 1'b0;
      chk_en = 1'b1;
      @(negedge clk);
      chk("ready_after_reset", ready_m, 1'b1);

      // 1: MSB-first 8'hA5 -> 1,0,1,0,0,1,0,1 then idle
      @(posedge clk); #1;
      send(8'hA5, 1'b0);
      check_frame(8'hA5, 1'b0, "t1");
      @(negedge clk);
      chk("t1_idle_valid", valid_m, 1'b0);
      chk("t1_idle_ready", ready_m, 1'b1);

      // 2: back-to-back frames, no gap
      @(posedge clk); #1;
      send(8'hA5, 1'b0);
      fork
         send(8'h3C, 1'b0);
         for (int i = 0; i < 2 * FL; i++) begin
            @(negedge clk);
            chk("t2_contig_valid", valid_m, 1'b1);
            chk("t2_fs", fs_m, (i == 0) || (i == FL));
         end
      join

      // 3: LSB-first 8'h01 -> 1 then seven 0s
      @(posedge clk); #1;
      send(8'h01, 1'b0);
      check_frame(8'h01, 1'b1, "t3");

      // 4: valid held and data churned while busy
      @(posedge clk); #1;
      send(8'h5A, 1'b1);
      fork
         check_frame(8'h5A, 1'b0, "t4");
         begin
            for (int i = 0; i < 5; i++) begin
               par_data = W'($urandom);
               @(posedge clk); #1;
            end
            par_valid = 1'b0;
         end
      join

      // 5: reset after 3 bits of 8'hFF, with par_valid high during reset
      @(posedge clk); #1;
      send(8'hFF, 1'b0);
      repeat (2) begin
         @(posedge clk); #1;
      end
      rst       = 1'b1;
      par_valid = 1'b1;
      par_data  = 8'h99;
      @(posedge clk); #1;
      rst       = 1'b0;
      par_valid = 1'b0;
      @(negedge clk);
      chk("t5_abort_valid", valid_m, 1'b0);
      chk("t5_abort_out",   out_m,   1'b0);
      chk("t5_ready",       ready_m, 1'b1);
      @(posedge clk); #1;
      send(8'hC3, 1'b0);
      check_frame(8'hC3, 1'b0, "t5");

      // 6: 8'h07 (three ones, parity bit 1 in the parity build)
      @(posedge clk); #1;
      send(8'h07, 1'b0);
      check_frame(8'h07, 1'b0, "t6");

      // random traffic with occasional resets
      for (int i = 0; i < 500; i++) begin
         @(posedge clk); #1;
         rst       = ($urandom_range(0, 79) == 0);
         par_valid = ($urandom_range(0, 3) != 0);
         par_data  = W'($urandom);
      end
      @(posedge clk); #1;
      rst       = 1'b0;
      par_valid = 1'b0;
      repeat (FL + 3) @(posedge clk);
      @(negedge clk);

      $display("Result: errors=%0d of %0d checks", n_err, n_checks);
      $finish;
   end

endmodule
